counter_bank: RTL and testbench
===============================

// Module: counter_bank
// PURPOSE
//  - Bank of CHANNELS independent modulo-MODULUS counters. Successor to the single 4-bit free-running counter.
//  - Adds per-channel enable, up/down direction, synchronous clear and load, a terminal-count pulse and a sticky wrap flag.
//  - Used as an event/period counter in testbenches and small datapaths; count values can be logged via huntest.
// PARAMETERS
//  CHANNELS  4   number of independent counter channels (>=1)
//  MODULUS   16  counts span 0..MODULUS-1 (>=2); COUNT_W = $clog2(MODULUS) is a localparam
// PORTS
//  clock        in   1               single clock, all logic on posedge
//  reset        in   1               asynchronous, active-high; clears all state
//  en           in   CHANNELS        per-channel count enable
//  dir          in   CHANNELS        0 = up, 1 = down (counter_pkg::dir_e)
//  clear        in   CHANNELS        synchronous clear to 0
//  load         in   CHANNELS        synchronous load of load_value
//  load_value   in   CHANNELS*COUNT_W  packed [CHANNELS][COUNT_W] load data
//  wrapped_clr  in   CHANNELS        clears sticky wrapped flag
//  count        out  CHANNELS*COUNT_W  packed [CHANNELS][COUNT_W] current counts
//  tc           out  CHANNELS        terminal-count pulse, registered
//  wrapped      out  CHANNELS        sticky wrap/overflow flag
// BEHAVIOUR
//  - Reset (async assert, sync release): count=0, tc=0, wrapped=0 for all channels, regardless of the clock.
//  - Per-channel priority on each posedge: clear > load > en. Idle (none asserted): count holds, tc=0.
//  - clear: count<=0, tc<=0. wrapped is unaffected (only wrapped_clr/reset clear it).
//  - load: count<=min(load_value, MODULUS-1), so out-of-range values clamp. tc<=0.
//  - en, up: count==MODULUS-1 -> 0 (wrap event); otherwise count+1.
//  - en, down: count==0 -> MODULUS-1 (wrap event); otherwise count-1.
//  - Arithmetic is COUNT_W-bit, explicit compare at the bound; never relies on a natural 2^W wrap.
//    This stays correct for non-power-of-2 MODULUS.
//  - tc: high for exactly the one cycle after the edge that caused a wrap event; back-to-back wraps give tc high in consecutive cycles.
//  - wrapped: set on a wrap event, cleared by wrapped_clr. Simultaneous wrap and wrapped_clr -> set wins.
//  - Latency: every output is registered; 1-cycle latency from input sampling to output.
//  - Channels are fully independent; no cross-channel interaction.
//  - dir change while counting takes effect on the next enabled edge; no glitch state.
// CONFIGURATION
//  COUNTER_BANK_SATURATE_EN defined:
//   - Counting up at MODULUS-1 holds MODULUS-1; counting down at 0 holds 0.
//   - Each enabled step attempted past a bound is a wrap event: tc pulses, wrapped sets.
//   - tc therefore stays high for every cycle en is held at the bound.
//  COUNTER_BANK_SATURATE_EN undefined: wrap-around behaviour as above.
//  clear/load/reset behaviour is identical in both builds.
// STRUCTURE
//  - counter_pkg holds typedef enum logic {DIR_UP=1'b0, DIR_DOWN=1'b1} dir_e.
//  - counter_pkg also holds function clog2_min1(int) so MODULUS=2 still gives COUNT_W=1.
//  - Sub-module counter_channel (one counter + tc + wrapped) is instantiated CHANNELS times in a generate loop.
//  - counter_bank only packs and unpacks the channel vectors.
// TESTING (CHANNELS=2, MODULUS=10, wrap build unless stated)
//  1. Count ch0 up to 5, assert reset between clock edges -> count[0]=0, tc=0, wrapped=0 immediately, before the next edge.
//  2. ch0 en=1 dir=up from 0 for 10 edges -> count 9 after edge 9, 0 after edge 10.
//     tc[0]=1 for one cycle, wrapped[0]=1; ch1 stays 0.
//  3. ch1 dir=down from 0, one enabled edge -> count[1]=9, tc[1] pulses, wrapped[1]=1.
//  4. ch0 clear+load+en same edge -> 0. Then load=7 with en -> 7. Then load=12 -> 9 (clamped).
//  5. ch0 at 9, en up and wrapped_clr same edge -> count 0, wrapped[0] stays 1.
//     Next edge with wrapped_clr only -> wrapped[0]=0.
//  6. COUNTER_BANK_SATURATE_EN: ch0 at 9, en up held 3 edges -> count stays 9, tc[0] high 3 cycles.
//     At 0 counting down -> holds 0, tc[0] pulses.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter bank.
// Holds the count-direction enum and a clog2 variant that never returns 0,
// so a two-state counter still gets a one-bit count register.
package counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Width needed to hold 0..n-1, with a floor of one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One modulo-MODULUS counter with terminal-count pulse and sticky wrap flag.
// Priority on each edge is clear > load > en; the bound is always an explicit
// compare, so a non-power-of-two MODULUS wraps correctly.
// Build option: COUNTER_BANK_SATURATE_EN makes the counter hold at the bound
// instead of wrapping; a step attempted past the bound is still a wrap event.
module counter_channel
  import counter_pkg::*;
#(
  parameter int MODULUS = 16,
  parameter int COUNT_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic               dir,
  input  logic               clear,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  input  logic               wrapped_clr,
  output logic [COUNT_W-1:0] count,
  output logic               tc,
  output logic               wrapped
);

  localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(MODULUS - 1);

  logic [COUNT_W-1:0] count_reg;
  logic [COUNT_W-1:0] count_next;
  logic               tc_reg;
  logic               tc_next;
  logic               wrapped_reg;
  logic               wrapped_next;
  logic               wrap_event;
  dir_e               dir_sel;

  assign dir_sel = dir_e'(dir);

  // Next-state selection: clear beats load beats enable; detect wrap events.
  always_comb begin
    count_next = count_reg;
    wrap_event = 1'b0;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end else if (en) begin
      if (dir_sel == DIR_UP) begin
        if (count_reg == MAX_VAL) begin
          wrap_event = 1'b1;
`ifdef COUNTER_BANK_SATURATE_EN
          count_next = MAX_VAL;
`else
          count_next = '0;
`endif
        end else begin
          count_next = count_reg + 1'b1;
        end
      end else begin
        if (count_reg == '0) begin
          wrap_event = 1'b1;
`ifdef COUNTER_BANK_SATURATE_EN
          count_next = '0;
`else
          count_next = MAX_VAL;
`endif
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
    end
    tc_next = wrap_event;
    // A wrap on the same edge as a flag clear leaves the flag set.
    if (wrap_event) begin
      wrapped_next = 1'b1;
    end else if (wrapped_clr) begin
      wrapped_next = 1'b0;
    end else begin
      wrapped_next = wrapped_reg;
    end
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg   <= '0;
      tc_reg      <= 1'b0;
      wrapped_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      tc_reg      <= tc_next;
      wrapped_reg <= wrapped_next;
    end
  end

  assign count   = count_reg;
  assign tc      = tc_reg;
  assign wrapped = wrapped_reg;

endmodule

// File: rtl/counter_bank.sv
// Bank of CHANNELS independent modulo-MODULUS counters.
// This level only fans the packed port vectors out to counter_channel
// instances and gathers their outputs back; channels never interact.
// Build option: COUNTER_BANK_SATURATE_EN (see counter_channel) selects
// saturating rather than wrapping counters.
module counter_bank
  import counter_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int MODULUS  = 16,
  localparam int COUNT_W = clog2_min1(MODULUS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [CHANNELS-1:0]              en,
  input  logic [CHANNELS-1:0]              dir,
  input  logic [CHANNELS-1:0]              clear,
  input  logic [CHANNELS-1:0]              load,
  input  logic [CHANNELS-1:0][COUNT_W-1:0] load_value,
  input  logic [CHANNELS-1:0]              wrapped_clr,
  output logic [CHANNELS-1:0][COUNT_W-1:0] count,
  output logic [CHANNELS-1:0]              tc,
  output logic [CHANNELS-1:0]              wrapped
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      counter_channel #(
        .MODULUS (MODULUS),
        .COUNT_W (COUNT_W)
      ) u_chan (
        .clock       (clock),
        .reset       (reset),
        .en          (en[gi]),
        .dir         (dir[gi]),
        .clear       (clear[gi]),
        .load        (load[gi]),
        .load_value  (load_value[gi]),
        .wrapped_clr (wrapped_clr[gi]),
        .count       (count[gi]),
        .tc          (tc[gi]),
        .wrapped     (wrapped[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_counter_bank.sv
// Scoreboard bench for counter_bank with CHANNELS=2, MODULUS=10.
// The driver applies inputs on the falling edge and queues the expected
// post-edge outputs; a monitor pops one entry per sample event and compares.
module tb_counter_bank;

  logic            clock;
  logic            reset;
  logic [1:0]      en;
  logic [1:0]      dir;
  logic [1:0]      clear;
  logic [1:0]      load;
  logic [1:0][3:0] load_value;
  logic [1:0]      wrapped_clr;
  logic [1:0][3:0] count;
  logic [1:0]      tc;
  logic [1:0]      wrapped;

  typedef struct {
    string      name;
    logic [3:0] c0;
    logic [3:0] c1;
    logic [1:0] tc;
    logic [1:0] wr;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks = 0;
  int   passed = 0;

  counter_bank #(
    .CHANNELS (2),
    .MODULUS  (10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .dir         (dir),
    .clear       (clear),
    .load        (load),
    .load_value  (load_value),
    .wrapped_clr (wrapped_clr),
    .count       (count),
    .tc          (tc),
    .wrapped     (wrapped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sample point shortly after each rising edge.
  always @(posedge clock) begin
    #1;
    -> sample_ev;
  end

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (count[0] === e.c0 && count[1] === e.c1 && tc === e.tc && wrapped === e.wr) begin
          passed++;
          $display("ok   %-16s count0=%0d count1=%0d tc=%b wrapped=%b", e.name, count[0], count[1], tc, wrapped);
        end else begin
          $display("FAIL %-16s got count0=%0d count1=%0d tc=%b wrapped=%b, expected count0=%0d count1=%0d tc=%b wrapped=%b",
                   e.name, count[0], count[1], tc, wrapped, e.c0, e.c1, e.tc, e.wr);
        end
      end
    end
  end

  function automatic exp_t mk(input string n, input logic [3:0] c0, input logic [3:0] c1,
                              input logic [1:0] t, input logic [1:0] w);
    exp_t e;
    e.name = n;
    e.c0   = c0;
    e.c1   = c1;
    e.tc   = t;
    e.wr   = w;
    return e;
  endfunction

  // One clock of stimulus plus the outputs expected after the next rising edge.
  task automatic step(input string n, input logic [1:0] en_i, input logic [1:0] dir_i,
                      input logic [1:0] clr_i, input logic [1:0] ld_i,
                      input logic [3:0] lv0, input logic [3:0] lv1, input logic [1:0] wclr_i,
                      input logic [3:0] c0, input logic [3:0] c1,
                      input logic [1:0] t, input logic [1:0] w);
    @(negedge clock);
    en          = en_i;
    dir         = dir_i;
    clear       = clr_i;
    load        = ld_i;
    load_value[0] = lv0;
    load_value[1] = lv1;
    wrapped_clr = wclr_i;
    exp_q.push_back(mk(n, c0, c1, t, w));
  endtask

  initial begin
    reset       = 1'b1;
    en          = '0;
    dir         = '0;
    clear       = '0;
    load        = '0;
    load_value  = '0;
    wrapped_clr = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    step("reset_state", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);

    // Count ch0 to 5, then assert reset between edges.
    for (int i = 1; i <= 5; i++)
      step("count_to_5", 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 4'(i), 0, 2'b00, 2'b00);
    @(negedge clock);
    en = '0;
    #2;
    reset = 1'b1;
    exp_q.push_back(mk("async_reset", 0, 0, 2'b00, 2'b00));
    #1;
    -> sample_ev;
    @(negedge clock);
    reset = 1'b0;

    // Clear beats load beats enable; load clamps to 9.
    step("clr_ld_en", 2'b01, 2'b00, 2'b01, 2'b01, 5, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    step("load_7", 2'b01, 2'b00, 2'b00, 2'b01, 7, 0, 2'b00, 7, 0, 2'b00, 2'b00);
    step("load_12_clamp", 2'b00, 2'b00, 2'b00, 2'b01, 12, 0, 2'b00, 9, 0, 2'b00, 2'b00);
    step("load_ch1_15", 2'b00, 2'b00, 2'b00, 2'b10, 0, 15, 2'b00, 9, 9, 2'b00, 2'b00);
    step("clear_both", 2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);

`ifdef COUNTER_BANK_SATURATE_EN
    step("sat_load_9", 2'b00, 2'b00, 2'b00, 2'b01, 9, 0, 2'b00, 9, 0, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++)
      step("sat_up_hold", 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 9, 0, 2'b01, 2'b01);
    step("sat_load_0", 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 2'b01);
    step("sat_down_hold", 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b01, 2'b01);
    step("sat_idle", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b01);
`else
    // Ten enabled up edges from 0: 1..9 then wrap to 0.
    for (int i = 1; i <= 9; i++)
      step("up_run", 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 4'(i), 0, 2'b00, 2'b00);
    step("up_wrap", 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b01, 2'b01);
    step("tc_one_cycle", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b01);

    // ch1 down from 0 wraps to 9.
    step("ch1_down_wrap", 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 2'b00, 0, 9, 2'b10, 2'b11);
    step("ch1_idle", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 9, 2'b00, 2'b11);

    // Wrap and flag clear on the same edge: set wins.
    step("ch0_load_9", 2'b00, 2'b00, 2'b00, 2'b01, 9, 0, 2'b00, 9, 9, 2'b00, 2'b11);
    step("wrap_vs_wclr", 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 0, 9, 2'b01, 2'b11);
    step("wclr_ch0", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 0, 9, 2'b00, 2'b10);

    // Back-to-back wraps: ch0 down from 0 then up from 9.
    step("b2b_down", 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 2'b10, 9, 9, 2'b01, 2'b01);
    step("b2b_up", 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 9, 2'b01, 2'b01);
    step("ch1_down_8", 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 2'b00, 0, 8, 2'b00, 2'b01);
    step("final_idle", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 8, 2'b00, 2'b01);
`endif

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(posedge clock);
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain_timeout got %0d pending entries, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
